// File: rtl/serial_subtractor8_pkg.sv
// Shared constants and FSM state encoding for the bit-serial subtractor.
package serial_subtractor8_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor8_fullsub.sv
// Single-bit full-subtractor cell: diff = a - b - bin, with borrow-out.
module fullsub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor8.sv
// Bit-serial subtractor, LSB first, one bit per clock through a single fullsub cell.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module serial_subtractor8
  import serial_subtractor8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sr_a, sr_b, sr_d;
  logic               brw;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;
  logic               bit_diff, bit_brw;
`ifdef SUB_OVF_EN
  logic               a_msb, b_msb;
`endif

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  fullsub u_cell (
    .a    (sr_a[0]),
    .b    (sr_b[0]),
    .bin  (brw),
    .diff (bit_diff),
    .bout (bit_brw)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand/result shift registers are cleared too, so an aborted run leaves nothing behind.
      sr_a  <= '0;
      sr_b  <= '0;
      sr_d  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr_a  <= a;
            sr_b  <= b;
            brw   <= bin;
            cnt   <= '0;
`ifdef SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          sr_a <= sr_a >> 1;
          sr_b <= sr_b >> 1;
          sr_d <= {bit_diff, sr_d[WIDTH-1:1]};
          brw  <= bit_brw;
          cnt  <= cnt + CNT_W'(1);
          // Visible outputs only move on the final bit, so they hold steady through RUN.
          if (last_bit) begin
            d    <= {bit_diff, sr_d[WIDTH-1:1]};
            bout <= bit_brw;
`ifdef SUB_OVF_EN
            ovf  <= (a_msb != b_msb) & (bit_diff != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
